// File: rtl/ro_meas_pkg.sv
// Shared types and defaults for the ring-oscillator measurement sequencer.
// Latency: n/a (types only). Backpressure: n/a.
package ro_meas_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        GATE,
        SETTLE,
        CAPTURE
    } meas_state_t;

    localparam int CLR_CYC_DEF    = 4;
    localparam int SETTLE_CYC_DEF = 4;

    localparam logic [15:0] RESULT_SAT = 16'hFFFF;

endpackage

// File: rtl/msb_wrap_det.sv
// Synchronises the RO counter MSB into clk and flags its 1->0 wrap while armed.
// Latency: SYNC_STAGES+1 clk from MSB fall to pulse. Backpressure: none, pulse is one cycle.
module msb_wrap_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic msb,
    input  logic arm,
    output logic wrap_pulse
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], msb};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign wrap_pulse = arm & prev_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/ro_meas_ctrl.sv
// Sequences one RO measurement: clear, gate for gate_len clk cycles, settle, capture.
// Latency: CLR_CYC+gate_len+SETTLE_CYC+2 clk start->done. Backpressure: start ignored while busy.
module ro_meas_ctrl
    import ro_meas_pkg::*;
#(
    parameter int GATE_W      = 16,
    parameter int CLR_CYC     = CLR_CYC_DEF,
    parameter int SETTLE_CYC  = SETTLE_CYC_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [GATE_W-1:0] gate_len,
    input  logic [7:0]        count_in,
    output logic              cnt_clr,
    output logic              cnt_en,
    output logic              busy,
    output logic              done,
    output logic [15:0]       result,
    output logic              ovf
);

    localparam logic [GATE_W-1:0] ONE         = GATE_W'(1);
    localparam logic [GATE_W-1:0] CLR_LAST    = GATE_W'(CLR_CYC - 1);
    localparam logic [GATE_W-1:0] SETTLE_LAST = GATE_W'(SETTLE_CYC - 1);

    meas_state_t       state, nxt;
    logic [GATE_W-1:0] tmr;
    logic [GATE_W-1:0] gate_q;
    logic [7:0]        wrap_cnt;
    logic              sat;
    logic              arm;
    logic              wrap_pulse;
    logic              capture_go;

    // Armed through SETTLE so edges still in flight through the synchroniser are counted.
    assign arm        = (state == GATE) || (state == SETTLE);
    assign capture_go = (state == CAPTURE) && !abort;

    msb_wrap_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_wrap_det (
        .clk       (clk),
        .rst       (rst),
        .msb       (count_in[7]),
        .arm       (arm),
        .wrap_pulse(wrap_pulse)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start)                    nxt = CLEAR;
            CLEAR:   if (tmr == CLR_LAST)          nxt = GATE;
            GATE:    if (tmr == (gate_q - ONE))    nxt = SETTLE;
            SETTLE:  if (tmr == SETTLE_LAST)       nxt = CAPTURE;
            CAPTURE:                               nxt = IDLE;
            default:                               nxt = IDLE;
        endcase
        if ((state != IDLE) && abort) begin
            nxt = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            tmr      <= '0;
            gate_q   <= '0;
            wrap_cnt <= '0;
            sat      <= 1'b0;
            result   <= '0;
            ovf      <= 1'b0;
            cnt_clr  <= 1'b0;
            cnt_en   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state <= nxt;
            tmr   <= (nxt != state) ? '0 : tmr + ONE;

            // Outputs follow the next state so they line up with the state register.
            cnt_clr <= (nxt == CLEAR);
            cnt_en  <= (nxt == GATE);
            busy    <= (nxt != IDLE);
            done    <= capture_go;

            if ((state == IDLE) && start) begin
                gate_q   <= (gate_len == '0) ? ONE : gate_len;
                wrap_cnt <= '0;
                sat      <= 1'b0;
            end else if (wrap_pulse) begin
                if (wrap_cnt == 8'hFF) begin
                    sat <= 1'b1;
                end else begin
                    wrap_cnt <= wrap_cnt + 8'd1;
                end
            end

            // count_in has been frozen for SETTLE_CYC cycles, so sampling it directly is safe.
            if (capture_go) begin
                result <= sat ? RESULT_SAT : {wrap_cnt, count_in};
                ovf    <= sat;
            end
        end
    end

endmodule

// File: tb/tb_ro_meas_ctrl.sv
// Directed bench for ro_meas_ctrl with a behavioural RO counter model.
module tb_ro_meas_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] gate_len = '0;
    logic [7:0]  ro_cnt = '0;
    logic        cnt_clr, cnt_en, busy, done, ovf;
    logic [15:0] result;
    int          rate = 0;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] gl;
        int          rate;
        logic [15:0] res;
        logic        ovf;
        int          nen;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    ro_meas_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .gate_len(gate_len),
        .count_in(ro_cnt),
        .cnt_clr (cnt_clr),
        .cnt_en  (cnt_en),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    // RO counter: cleared while cnt_clr, advances rate counts per clk cycle while cnt_en.
    always @(posedge clk) begin
        #1;
        if (cnt_clr)     ro_cnt = 8'd0;
        else if (cnt_en) ro_cnt = ro_cnt + 8'(rate);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at #2 after an edge; returns edges until done (0 if it never came).
    task automatic run_meas(input logic [15:0] gl, input int rt,
                            output int lat, output int nclr, output int nen);
        gate_len = gl;
        rate     = rt;
        start    = 1'b1;
        lat = 0; nclr = 0; nen = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            nclr += int'(cnt_clr);
            nen  += int'(cnt_en);
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk); #2;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    initial begin
        int lat, nclr, nen, ndone, en_seen;

        vecs[0] = '{16'd10,   5,   16'h0032, 1'b0, 10,   20};
        vecs[1] = '{16'd100,  7,   16'h02BC, 1'b0, 100,  110};
        vecs[2] = '{16'd1000, 100, 16'hFFFF, 1'b1, 1000, 1010};
        vecs[3] = '{16'd0,    5,   16'h0005, 1'b0, 1,    11};
        vecs[4] = '{16'd51,   5,   16'h00FF, 1'b0, 51,   61};
        vecs[5] = '{16'd52,   5,   16'h0104, 1'b0, 52,   62};

        repeat (3) @(posedge clk);
        #2;
        check("reset_outputs", {12'd0, cnt_clr, cnt_en, busy, done, ovf, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;

        for (int k = 0; k < 6; k++) begin
            run_meas(vecs[k].gl, vecs[k].rate, lat, nclr, nen);
            check($sformatf("v%0d_clr_cycles", k), nclr, 4);
            check($sformatf("v%0d_en_cycles", k), nen, vecs[k].nen);
            check($sformatf("v%0d_latency", k), lat, vecs[k].lat);
            check($sformatf("v%0d_result", k), result, vecs[k].res);
            check($sformatf("v%0d_ovf", k), ovf, vecs[k].ovf);
            repeat (2) @(posedge clk);
            #2;
        end

        // start pulses while busy must not queue a second measurement
        gate_len = 16'd10; rate = 5; start = 1'b1;
        ndone = 0;
        for (int i = 1; i <= 45; i++) begin
            @(posedge clk); #2;
            start = (i == 6 || i == 12 || i == 18);
            ndone += int'(done);
        end
        start = 1'b0;
        check("busy_start_done_count", ndone, 1);
        check("busy_start_result", result, 16'h0032);

        // start in the done cycle launches the next measurement
        run_meas(16'd10, 5, lat, nclr, nen);
        check("first_run_latency", lat, 20);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        check("done_cycle_start_busy", busy, 1'b1);
        check("done_cycle_start_clr", cnt_clr, 1'b1);
        wait_done(100, lat);
        check("second_run_latency", lat, 19);
        check("second_run_result", result, 16'h0032);

        // abort in the third GATE cycle
        repeat (2) @(posedge clk);
        #2;
        gate_len = 16'd10; rate = 5; start = 1'b1;
        en_seen = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            en_seen += int'(cnt_en);
            if (en_seen == 3) break;
        end
        check("abort_reached_gate3", en_seen, 3);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        check("abort_en_low", cnt_en, 1'b0);
        check("abort_busy_low", busy, 1'b0);
        ndone = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #2;
            ndone += int'(done);
        end
        check("abort_no_done", ndone, 0);
        check("abort_result_kept", result, 16'h0032);
        check("abort_ovf_kept", ovf, 1'b0);

        // start and abort together in IDLE: start wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
        check("start_beats_abort", {busy, cnt_clr}, 2'b11);
        wait_done(100, lat);
        check("start_beats_abort_latency", lat, 19);

        // asynchronous reset mid-GATE
        repeat (2) @(posedge clk);
        #2;
        gate_len = 16'd100; rate = 3; start = 1'b1;
        en_seen = 0;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk); #2;
            start = 1'b0;
            en_seen += int'(cnt_en);
            if (en_seen == 5) break;
        end
        check("rst_reached_gate", cnt_en, 1'b1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {12'd0, cnt_clr, cnt_en, busy, done, ovf, result}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #2;
        run_meas(16'd10, 5, lat, nclr, nen);
        check("post_rst_latency", lat, 20);
        check("post_rst_en_cycles", nen, 10);
        check("post_rst_result", result, 16'h0032);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
